// File: rtl/ieee80211_interleaver_pp.sv
// ieee80211_interleaver_pp
//   802.11a/g OFDM block interleaver (MODE=0) / deinterleaver (MODE=1) with
//   two ping-pong symbol banks of 288 bits.
// Ports:
//   aclk, aresetn           clock, asynchronous active-low reset
//   s_axis_t{data,user,valid,ready,last}  coded bits in; tuser = rate code,
//                           sampled on beat 0 of each symbol
//   m_axis_t{data,user,valid,ready,last}  permuted bits out; tuser = rate of
//                           the symbol, tlast on the final beat of a packet
module ieee80211_interleaver_pp #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MODE       = 0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [3:0]            s_axis_tuser,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [3:0]            m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int unsigned NMAX = 288;
  localparam int unsigned CW   = 9;

  // Beat index of the final beat for each rate class (48/96/192/288 bits).
  localparam logic [CW-1:0] LAST_BEAT [4] = '{
    CW'(48 / DATA_WIDTH - 1),  CW'(96 / DATA_WIDTH - 1),
    CW'(192 / DATA_WIDTH - 1), CW'(288 / DATA_WIDTH - 1)
  };

  function automatic int unsigned cls_n(input int unsigned c);
    case (c)
      0:       return 48;
      1:       return 96;
      2:       return 192;
      default: return 288;
    endcase
  endfunction

  function automatic int unsigned cls_s(input int unsigned c);
    case (c)
      0, 1:    return 1;
      2:       return 2;
      default: return 3;
    endcase
  endfunction

  // Forward 802.11 permutation k -> j (both steps).
  function automatic int unsigned il_map(input int unsigned c, input int unsigned k);
    int unsigned n, s, i;
    n = cls_n(c);
    s = cls_s(c);
    i = (n / 16) * (k % 16) + k / 16;
    return s * (i / s) + (i + n - (16 * i) / n) % s;
  endfunction

  // Input bit that lands on output position p (elaboration-time only).
  function automatic int unsigned src_idx(input int unsigned c, input int unsigned p);
    int unsigned r;
    r = 0;
    if (MODE == 0) begin
      for (int unsigned k = 0; k < cls_n(c); k++)
        if (il_map(c, k) == p) r = k;
    end else begin
      r = il_map(c, p);
    end
    return r;
  endfunction

  // Rate code to class; unknown codes fall back to the 48-bit class.
  function automatic logic [1:0] rate_cls(input logic [3:0] r);
    case (r)
      4'hD, 4'hF: return 2'd0;
      4'h5, 4'h7: return 2'd1;
      4'h9, 4'hB: return 2'd2;
      4'h1, 4'h3: return 2'd3;
      default:    return 2'd0;
    endcase
  endfunction

  logic            run;
  logic [1:0]      full, full_c, last_q;
  logic [3:0]      rate_q [2];
  logic [NMAX-1:0] bank_q [2];
  logic            wr_sel, rd_sel;
  logic [CW-1:0]   wr_cnt, rd_cnt;
  logic [1:0]      wr_cls_q, wr_cls_c, rd_cls;
  logic            wr_fire, wr_close, rd_load, rd_final;
  int unsigned     wr_off, rd_off;
  logic [NMAX-1:0] rd_bits, perm_sel;
  logic [NMAX-1:0] perm [4];
  logic [DATA_WIDTH-1:0] rd_beat;

  assign s_axis_tready = run & ~full[wr_sel];

  // Write-side control: class comes from tuser on beat 0, latched after.
  always_comb begin
    wr_cls_c = (wr_cnt == '0) ? rate_cls(s_axis_tuser) : wr_cls_q;
    wr_fire  = s_axis_tvalid & s_axis_tready;
    wr_close = wr_fire & ((wr_cnt == LAST_BEAT[wr_cls_c]) | s_axis_tlast);
    wr_off   = 32'(wr_cnt) * DATA_WIDTH;
  end

  // Read-side control and beat extraction from the permuted bank.
  always_comb begin
    rd_cls   = rate_cls(rate_q[rd_sel]);
    rd_load  = full[rd_sel] & (~m_axis_tvalid | m_axis_tready);
    rd_final = (rd_cnt == LAST_BEAT[rd_cls]);
    rd_bits  = bank_q[rd_sel];
    perm_sel = perm[rd_cls];
    rd_off   = 32'(rd_cnt) * DATA_WIDTH;
    rd_beat  = DATA_WIDTH'(perm_sel >> rd_off);
  end

  // Fixed wiring of the permutation for every rate class.
  for (genvar c = 0; c < 4; c++) begin : g_cls
    for (genvar p = 0; p < NMAX; p++) begin : g_bit
      if (p < cls_n(c)) begin : g_map
        localparam int unsigned SRC = src_idx(c, p);
        assign perm[c][p] = rd_bits[SRC];
      end else begin : g_pad
        assign perm[c][p] = 1'b0;
      end
    end
  end

  // Bank full flags: set by a closing write, cleared by the final read load.
  always_comb begin
    full_c = full;
    if (wr_close)            full_c[wr_sel] = 1'b1;
    if (rd_load && rd_final) full_c[rd_sel] = 1'b0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run  <= 1'b0;
      full <= '0;
    end else begin
      run  <= 1'b1;
      full <= full_c;
    end
  end

  // Bank storage; beat 0 clears the rest of the bank so short symbols zero-fill.
  always_ff @(posedge aclk) begin
    if (wr_fire) begin
      if (wr_cnt == '0) bank_q[wr_sel] <= NMAX'(s_axis_tdata);
      else              bank_q[wr_sel] <= bank_q[wr_sel] | (NMAX'(s_axis_tdata) << wr_off);
    end
  end

  // Write pointer, beat counter and per-bank metadata.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_sel    <= 1'b0;
      wr_cnt    <= '0;
      wr_cls_q  <= '0;
      last_q    <= '0;
      rate_q[0] <= '0;
      rate_q[1] <= '0;
    end else if (wr_fire) begin
      if (wr_cnt == '0) begin
        rate_q[wr_sel] <= s_axis_tuser;
        wr_cls_q       <= wr_cls_c;
      end
      if (wr_close) begin
        last_q[wr_sel] <= s_axis_tlast;
        wr_sel         <= ~wr_sel;
        wr_cnt         <= '0;
      end else begin
        wr_cnt <= wr_cnt + CW'(1);
      end
    end
  end

  // Output register and read pointer.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_sel        <= 1'b0;
      rd_cnt        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (rd_load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= rd_beat;
      m_axis_tuser  <= rate_q[rd_sel];
      m_axis_tlast  <= rd_final & last_q[rd_sel];
      if (rd_final) begin
        rd_cnt <= '0;
        rd_sel <= ~rd_sel;
      end else begin
        rd_cnt <= rd_cnt + CW'(1);
      end
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ieee80211_interleaver_pp.sv
// Bench for ieee80211_interleaver_pp: directed and randomized symbols on an
// interleaver (W=8), plus an interleaver->deinterleaver chain for round trip.
module tb_ieee80211_interleaver_pp;

  localparam int unsigned W = 8;
  localparam logic [3:0] R6  = 4'hD, R9  = 4'hF, R12 = 4'h5, R18 = 4'h7;
  localparam logic [3:0] R24 = 4'h9, R36 = 4'hB, R48 = 4'h1, R54 = 4'h3;
  localparam logic [3:0] CODES [9] = '{R6, R9, R12, R18, R24, R36, R48, R54, 4'h0};

  typedef struct packed {
    logic [W-1:0] data;
    logic [3:0]   user;
    logic         last;
  } beat_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [W-1:0] s_data;
  logic [3:0]   s_user;
  logic         s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0, chain = 1'b0;

  logic [W-1:0] d_m_data, t_m_data, r_m_data;
  logic [3:0]   d_m_user, t_m_user, r_m_user;
  logic         d_s_ready, d_m_valid, d_m_last;
  logic         t_s_ready, t_m_valid, t_m_last, r_s_ready, r_m_valid, r_m_last;

  ieee80211_interleaver_pp #(.DATA_WIDTH(W), .MODE(0)) u_dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_data), .s_axis_tuser(s_user), .s_axis_tvalid(s_valid & ~chain),
    .s_axis_tready(d_s_ready), .s_axis_tlast(s_last),
    .m_axis_tdata(d_m_data), .m_axis_tuser(d_m_user), .m_axis_tvalid(d_m_valid),
    .m_axis_tready(m_ready & ~chain), .m_axis_tlast(d_m_last));

  ieee80211_interleaver_pp #(.DATA_WIDTH(W), .MODE(0)) u_tx (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_data), .s_axis_tuser(s_user), .s_axis_tvalid(s_valid & chain),
    .s_axis_tready(t_s_ready), .s_axis_tlast(s_last),
    .m_axis_tdata(t_m_data), .m_axis_tuser(t_m_user), .m_axis_tvalid(t_m_valid),
    .m_axis_tready(r_s_ready), .m_axis_tlast(t_m_last));

  ieee80211_interleaver_pp #(.DATA_WIDTH(W), .MODE(1)) u_rx (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(t_m_data), .s_axis_tuser(t_m_user), .s_axis_tvalid(t_m_valid),
    .s_axis_tready(r_s_ready), .s_axis_tlast(t_m_last),
    .m_axis_tdata(r_m_data), .m_axis_tuser(r_m_user), .m_axis_tvalid(r_m_valid),
    .m_axis_tready(m_ready & chain), .m_axis_tlast(r_m_last));

  logic  a_s_ready, a_m_valid;
  beat_t a_out;
  assign a_s_ready = chain ? t_s_ready : d_s_ready;
  assign a_m_valid = chain ? r_m_valid : d_m_valid;
  assign a_out     = chain ? {r_m_data, r_m_user, r_m_last} : {d_m_data, d_m_user, d_m_last};

  beat_t in_q[$], out_q[$], exp_q[$];
  int n_assert = 0, n_fail = 0;
  int cyc, acc_cnt, first_in, last_in, first_out, last_out, first_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned n_of(input logic [3:0] r);
    case (r)
      R12, R18: return 96;
      R24, R36: return 192;
      R48, R54: return 288;
      default:  return 48;
    endcase
  endfunction

  function automatic int unsigned s_of(input logic [3:0] r);
    case (r)
      R24, R36: return 2;
      R48, R54: return 3;
      default:  return 1;
    endcase
  endfunction

  // Reference interleaver: output bit j takes input bit k.
  function automatic logic [287:0] model(input logic [287:0] x, input logic [3:0] r);
    int unsigned n, s, i, j;
    logic [287:0] y;
    n = n_of(r);
    s = s_of(r);
    y = '0;
    for (int unsigned k = 0; k < n; k++) begin
      i = (n / 16) * (k % 16) + k / 16;
      j = s * (i / s) + (i + n - (16 * i) / n) % s;
      y[j] = x[k];
    end
    return y;
  endfunction

  function automatic logic [287:0] rand_bits();
    logic [287:0] v;
    for (int i = 0; i < 9; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Queue nb input beats of a symbol and its expected output beats.
  task automatic push_symbol(input logic [3:0] r, input logic [287:0] x, input int nb,
                             input bit last, input bit perm);
    int tot;
    bit is_short;
    logic [287:0] xm, y;
    tot = int'(n_of(r) / W);
    is_short = (nb < tot);
    xm = x;
    for (int b = nb * W; b < 288; b++) xm[b] = 1'b0;
    for (int i = 0; i < nb; i++)
      in_q.push_back(beat_t'{data: xm[i*W +: W], user: (i == 0) ? r : 4'($urandom),
                             last: (i == nb - 1) && (is_short || last)});
    y = perm ? model(xm, r) : xm;
    for (int m = 0; m < tot; m++)
      exp_q.push_back(beat_t'{data: y[m*W +: W], user: r,
                              last: (m == tot - 1) && (is_short || last)});
  endtask

  task automatic drive();
    if (in_q.size() > 0) begin
      s_valid = 1'b1;
      s_data  = in_q[0].data;
      s_user  = in_q[0].user;
      s_last  = in_q[0].last;
    end else begin
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  function automatic logic pick_ready(input int mode);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  task automatic clr_stats();
    cyc = 0; acc_cnt = 0; first_in = -1; last_in = -1;
    first_out = -1; last_out = -1; first_val = -1;
  endtask

  // Cycle loop: handshakes decided at negedge, drives updated after posedge.
  task automatic run(input int max_cyc, input int mode);
    bit    stall, acc_in, acc_out;
    beat_t held;
    stall = 1'b0;
    held  = '0;
    drive();
    m_ready = pick_ready(mode);
    for (int c = 0; c < max_cyc; c++) begin
      if (in_q.size() == 0 && out_q.size() >= exp_q.size()) break;
      @(negedge aclk);
      if (stall) chk("hold", 32'({a_m_valid, a_out}), 32'({1'b1, held}));
      acc_in  = s_valid && a_s_ready;
      acc_out = a_m_valid && m_ready;
      stall   = a_m_valid && !m_ready;
      held    = a_out;
      if (a_m_valid && first_val < 0) first_val = cyc;
      if (acc_out) begin
        out_q.push_back(a_out);
        last_out = cyc;
        if (first_out < 0) first_out = cyc;
      end
      if (acc_in) begin
        acc_cnt++;
        last_in = cyc;
        if (first_in < 0) first_in = cyc;
      end
      @(posedge aclk);
      #1;
      cyc++;
      if (acc_in) void'(in_q.pop_front());
      drive();
      m_ready = pick_ready(mode);
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_count"}, 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset(input string tag);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    chk({tag, "_mvalid"}, 32'(d_m_valid), 0);
    chk({tag, "_mdata"},  32'(d_m_data),  0);
    chk({tag, "_muser"},  32'(d_m_user),  0);
    chk({tag, "_mlast"},  32'(d_m_last),  0);
    chk({tag, "_sready"}, 32'(d_s_ready), 0);
    in_q.delete(); out_q.delete(); exp_q.delete();
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0; chain = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk({tag, "_sready_rel"}, 32'(d_s_ready), 0);
    @(posedge aclk);
    #1;
    chk({tag, "_sready_run"}, 32'(d_s_ready), 1);
  endtask

  initial begin
    logic [287:0] x;
    logic [3:0]   r;
    int           tot, nb;

    s_data = '0;
    s_user = '0;
    do_reset("rst0");

    // Single 1 at k=1, 6M: lands at j=3; also check first-beat latency.
    clr_stats();
    x = '0; x[1] = 1'b1;
    push_symbol(R6, x, 6, 1'b1, 1'b1);
    run(100, 1);
    if (out_q.size() > 0) chk("t1_beat0", 32'(out_q[0].data), 32'h08);
    chk("t1_latency", 32'(first_val - last_in), 2);
    check_out("t1");

    // Single 1 at k=1, 54M: lands at j=20 (beat 2, bit 4).
    clr_stats();
    x = '0; x[1] = 1'b1;
    push_symbol(R54, x, 36, 1'b0, 1'b1);
    run(200, 1);
    if (out_q.size() > 2) chk("t2_beat2", 32'(out_q[2].data), 32'h10);
    check_out("t2");

    // Unknown rate code behaves as a 48-bit symbol.
    clr_stats();
    push_symbol(4'h0, rand_bits(), 6, 1'b1, 1'b1);
    run(100, 2);
    check_out("t3");

    // Back-to-back equal-size symbols stream with no bubbles on either side.
    clr_stats();
    for (int i = 0; i < 4; i++) push_symbol(R36, rand_bits(), 24, i == 3, 1'b1);
    run(400, 1);
    chk("t4_in_span",  32'(last_in - first_in), 95);
    chk("t4_out_span", 32'(last_out - first_out), 95);
    check_out("t4");

    // Short packet: tlast on beat 4 of 12 zero-fills the rest.
    clr_stats();
    push_symbol(R12, rand_bits(), 5, 1'b1, 1'b1);
    run(100, 1);
    check_out("t5");

    // Output stalled: both banks fill, input blocks after 48 beats.
    clr_stats();
    for (int i = 0; i < 4; i++) push_symbol(R24, rand_bits(), 24, i == 3, 1'b1);
    run(80, 0);
    chk("t6_accepted", 32'(acc_cnt), 48);
    chk("t6_sready",   32'(d_s_ready), 0);
    run(3000, 2);
    check_out("t6");

    // Random rates, lengths, tlast and backpressure.
    clr_stats();
    for (int i = 0; i < 20; i++) begin
      r   = CODES[$urandom_range(0, 8)];
      tot = int'(n_of(r) / W);
      nb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, tot)) : tot;
      push_symbol(r, rand_bits(), nb, 1'($urandom_range(0, 1)), 1'b1);
    end
    run(8000, 2);
    check_out("t7");

    // Interleave then deinterleave returns the zero-filled input unchanged.
    clr_stats();
    chain = 1'b1;
    for (int i = 0; i < 30; i++) begin
      r   = CODES[$urandom_range(0, 8)];
      tot = int'(n_of(r) / W);
      nb  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, tot)) : tot;
      push_symbol(r, rand_bits(), nb, 1'($urandom_range(0, 1)), 1'b0);
    end
    run(20000, 2);
    check_out("t8");
    chain = 1'b0;

    // Reset with a held output beat and a partial symbol in flight.
    clr_stats();
    push_symbol(R6, rand_bits(), 6, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      in_q.push_back(beat_t'{data: W'($urandom), user: R54, last: 1'b0});
    run(20, 0);
    chk("t9_pre_valid", 32'(d_m_valid), 1);
    do_reset("rst1");
    clr_stats();
    push_symbol(R6, rand_bits(), 6, 1'b1, 1'b1);
    run(200, 1);
    check_out("t9");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ieee80211_interleaver_pp.md
Name: ieee80211_interleaver_pp

Overview:
Parametrised IEEE 802.11a/g OFDM block interleaver/deinterleaver with ping-pong symbol buffering. It collects one OFDM symbol of coded bits (N_CBPS = 48/96/192/288, selected per symbol by the rate code), applies the two-step 802.11 permutation (or its inverse) and streams the permuted symbol out at DATA_WIDTH bits per beat. It sits between the convolutional encoder/puncturer and the mapper on TX (MODE=0), or between the demapper and depuncturer on RX (MODE=1). Both sides sustain one beat per cycle.

Parameters:
DATA_WIDTH, 8, bits per AXI-Stream beat; legal values 1, 2, 4, 8, 16 (all divide 48).
MODE, 0, 0 = interleave (k -> j), 1 = deinterleave (j -> k).

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_axis_tdata  in  DATA_WIDTH  input bits; bit b of beat n is symbol bit n*DATA_WIDTH+b
s_axis_tuser  in  4  rate code (`RATE_* from ieee80211_defs.v), sampled on the first beat of each symbol
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last beat of packet
m_axis_tdata  out  DATA_WIDTH  permuted bits, same bit ordering as input
m_axis_tuser  out  4  rate code of the symbol being output
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  last beat of the last symbol of a packet

Behaviour:
- N_CBPS: 6M/9M=48 (s=1), 12M/18M=96 (s=1), 24M/36M=192 (s=2), 48M/54M=288 (s=3). Any other code is treated as 48.
- Interleave: i=(N/16)(k mod 16)+floor(k/16); j=s*floor(i/s)+(i+N-floor(16i/N)) mod s. Output bit j = input bit k. Deinterleave applies the exact inverse.
- Two banks of 288 bits. Each bank has a full flag, a stored rate and a stored last flag.
- Write side:
  - Fills bank wr_sel; s_axis_tready = run & ~full[wr_sel].
  - Rate is latched on beat 0. tuser on later beats is ignored.
  - On the final beat (N/DATA_WIDTH-1) the bank is set full, last is stored as s_axis_tlast, and wr_sel toggles.
- Short packet: s_axis_tlast on a non-final beat closes the symbol. Remaining bits read as 0, the bank is set full with last=1, and wr_sel toggles.
- run is a register cleared by reset and set on the first aclk edge after deassertion, so s_axis_tready=0 in reset and for that first edge.
- Read side:
  - Drains bank rd_sel through an output register that loads when ~m_axis_tvalid | m_axis_tready.
  - The beat counter advances per load. The load of beat N/DATA_WIDTH-1 clears full[rd_sel] and toggles rd_sel.
  - m_axis_tlast = stored last on that final beat, else 0. m_axis_tuser = stored rate on every beat.
- Latency: if the final input beat is accepted at edge E and the read side is idle, m_axis_tvalid rises at edge E+1 carrying beat 0.
- m_axis_tdata/tuser/tlast are held stable while m_axis_tvalid & ~m_axis_tready.
- Simultaneous events: a write completing one bank and a read releasing the other bank in the same cycle both take effect. The freed bank becomes writable on the next cycle.
- Full: with both banks full, s_axis_tready=0 until the first read-side bank release.
- Empty: m_axis_tvalid drops after the last beat handshake if no bank is full, with no bubble if the other bank is already full.
- Reset (any time, including mid-symbol): asynchronously clears banks' full flags, wr_sel, rd_sel and counters. m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, s_axis_tready=0. Partial symbols are discarded and bank contents need no reset.
- Counters are 9 bits (max 288 beats at DATA_WIDTH=1). All index arithmetic is done in constant generate-time tables, with no runtime division.

Test Plan:
- MODE=0, W=8, RATE_6M, 6 beats, single 1 at k=1 (beat0=0x02) -> 6 output beats, beat0=0x08 (j=3), others 0, tuser=RATE_6M, tlast per input.
- MODE=0, W=8, RATE_54M, 36 beats, single 1 at k=1 -> only output beat 2 nonzero, =0x10 (j=20).
- MODE=0 then MODE=1 in series, W=16, random data over all 8 rates back-to-back, 200 symbols -> output equals input bit-exact, tuser/tlast preserved, zero-bubble throughput with tready=1.
- m_axis_tready=0, stream RATE_24M symbols -> s_axis_tready drops after exactly 2×24 beats accepted (W=8). Raise tready -> data resumes in order, held values stable during the stall.
- RATE_12M, tlast on beat 4 of 12 (W=8) -> 12 output beats with zero-fill bits permuted into place, m_axis_tlast on beat 11 only.
- Assert aresetn low mid-symbol for 1 cycle -> all outputs 0 immediately, s_axis_tready low until one edge after release, next symbol processed correctly from beat 0.
